// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter. It merges single-cycle ALU results with buffered
// LSU load results into one registered write per cycle.
module rf_wb_arb #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            wr,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] wrdata,
  output logic            lsu_pend
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic          fifo_nonempty, push, lsu_grant, alu_grant;

  // Grant logic sees only registered FIFO state, so a same-cycle push is never bypassed.
  assign fifo_nonempty = (count != '0);
  assign lsu_ready     = !rst && (count != CW'(DEPTH));
  assign lsu_grant     = !rst && fifo_nonempty &&
                         (!alu_valid || starve_cnt == SW'(STARVE_MAX));
  assign alu_ready     = !rst && !lsu_grant;
  assign alu_grant     = alu_valid && alu_ready;
  assign push          = lsu_valid && lsu_ready;
  assign head          = mem[rptr];
  assign lsu_pend      = fifo_nonempty;

  // NOTE: storage has no reset; validity is tracked solely by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{rd: lsu_rd, data: lsu_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)      wptr <= wptr + PW'(1);
      if (lsu_grant) rptr <= rptr + PW'(1);
      case ({push, lsu_grant})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!fifo_nonempty || lsu_grant) begin
      starve_cnt <= '0;
    end else if (alu_grant && starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // x0 results update rd/wrdata like any other grant but never raise wr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr     <= 1'b0;
      rd     <= '0;
      wrdata <= '0;
    end else if (lsu_grant) begin
      wr     <= (head.rd != '0);
      rd     <= head.rd;
      wrdata <= head.data;
    end else if (alu_grant) begin
      wr     <= (alu_rd != '0);
      rd     <= alu_rd;
      wrdata <= alu_data;
    end else begin
      wr     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb. Stimulus queues the register-file writes it expects, and an
// independent monitor compares each write against that queue.
module tb_rf_wb_arb;

  logic        clk, rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, rd;
  logic [31:0] alu_data, lsu_data, wrdata;
  logic        wr, lsu_pend;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  rf_wb_arb dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wr(wr), .rd(rd), .wrdata(wrdata), .lsu_pend(lsu_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    @(posedge clk);
    #1;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back('{rd: r, data: d});
  endtask

  // Monitor: every write must match the oldest expected entry.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && wr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", {27'd0, rd, wrdata}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_rd", 64'(rd), 64'(e.rd));
          check("wr_data", 64'(wrdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h1;

    // Reset state; the ready outputs are forced low even with valid inputs present.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr", 64'(wr), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_wrdata", 64'(wrdata), 64'd0);
    check("rst_lsu_pend", 64'(lsu_pend), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd0);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    rst = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0;

    // ALU only.
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd5, 32'hDEAD_BEEF);
    @(negedge clk); check("t1_alu_ready", 64'(alu_ready), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk); check("t1_wr", 64'(wr), 64'd1);

    // LSU only: two loads are written in push order.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h11);
    expect_wr(5'd3, 32'h11);
    @(negedge clk);
    check("t2_lsu_ready", 64'(lsu_ready), 64'd1);
    check("t2_pend_push", 64'(lsu_pend), 64'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h22);
    expect_wr(5'd4, 32'h22);
    @(negedge clk);
    check("t2_pend1", 64'(lsu_pend), 64'd1);
    check("t2_alu_ready", 64'(alu_ready), 64'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk); check("t2_pend2", 64'(lsu_pend), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk); check("t2_pend_fall", 64'(lsu_pend), 64'd0);

    // Starvation: the entry lands with the first ALU grant, then 4 more ALU grants, then LSU.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd8, 32'hA000_0000 + i, (i == 0), 5'd7, 32'h77);
      expect_wr(5'd8, 32'hA000_0000 + i);
      @(negedge clk); check("t3_alu_ready", 64'(alu_ready), 64'd1);
    end
    drive(1'b1, 5'd8, 32'hA000_0005, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd7, 32'h77);
    @(negedge clk); check("t3_forced", 64'(alu_ready), 64'd0);
    drive(1'b1, 5'd8, 32'hA000_0005, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd8, 32'hA000_0005);
    @(negedge clk); check("t3_alu_back", 64'(alu_ready), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);

    // Full FIFO: two pushes, a third is refused, and a pop alone does not reopen it.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd9, 32'hB000_0000 + i, 1'b1,
            (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd12,
            (i == 0) ? 32'hC0 : (i == 1) ? 32'hC1 : 32'hC2);
      expect_wr(5'd9, 32'hB000_0000 + i);
      @(negedge clk);
      check("t4_lsu_ready", 64'(lsu_ready), (i < 2) ? 64'd1 : 64'd0);
      check("t4_alu_ready", 64'(alu_ready), 64'd1);
    end
    drive(1'b1, 5'd9, 32'hB000_0005, 1'b1, 5'd12, 32'hC2);
    expect_wr(5'd10, 32'hC0);
    @(negedge clk);
    check("t4_pop_alu_ready", 64'(alu_ready), 64'd0);
    check("t4_pop_no_bypass", 64'(lsu_ready), 64'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC2);
    expect_wr(5'd11, 32'hC1);
    @(negedge clk); check("t4_reopen", 64'(lsu_ready), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd12, 32'hC2);
    @(negedge clk); check("t4_pend_wrap", 64'(lsu_pend), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk); check("t4_empty", 64'(lsu_pend), 64'd0);

    // x0 destinations: the handshake completes but wr stays low.
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
    @(negedge clk); check("t5_alu_ready", 64'(alu_ready), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t5_wr", 64'(wr), 64'd0);
    check("t5_rd", 64'(rd), 64'd0);
    check("t5_wrdata", 64'(wrdata), 64'h1234);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk); check("t5_lsu_pend", 64'(lsu_pend), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t5_lsu_popped", 64'(lsu_pend), 64'd0);
    check("t5_lsu_wr", 64'(wr), 64'd0);
    check("t5_lsu_wrdata", 64'(wrdata), 64'h55);

    // Reset mid-operation with two buffered entries and an LSU grant about to commit.
    drive(1'b1, 5'd14, 32'hE0, 1'b1, 5'd13, 32'hD0);
    expect_wr(5'd14, 32'hE0);
    drive(1'b1, 5'd16, 32'hE1, 1'b1, 5'd15, 32'hD1);
    expect_wr(5'd16, 32'hE1);
    @(negedge clk); check("t6_pend", 64'(lsu_pend), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_wr", 64'(wr), 64'd0);
    check("t6_rst_pend", 64'(lsu_pend), 64'd0);
    check("t6_rst_alu_ready", 64'(alu_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      check("t6_no_stale_wr", 64'(wr), 64'd0);
      check("t6_no_stale_pend", 64'(lsu_pend), 64'd0);
    end

    check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
